// File: rtl/crack_result_collector.sv
// Collects the outcome of the parallel RC4 key-search cores: latches the first winning core
// and its key, freezes every core, then streams the winner's decrypted message over valid/ready.
module crack_result_collector #(
    parameter int unsigned CORE_NUMBER    = 4,
    parameter int unsigned MESSAGE_LENGTH = 32,
    parameter int unsigned KEY_WIDTH      = 24,
    parameter int unsigned IDX_W          = (CORE_NUMBER > 1) ? $clog2(CORE_NUMBER) : 1,
    localparam int unsigned ADDR_W        = 5,
    localparam int unsigned BYTE_W        = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [CORE_NUMBER-1:0]          core_cracked,
    input  logic [CORE_NUMBER-1:0]          core_failed,
    input  logic [CORE_NUMBER*KEY_WIDTH-1:0] core_key,
    output logic                            done,
    output logic [ADDR_W-1:0]               rd_address,
    input  logic [CORE_NUMBER*BYTE_W-1:0]   rd_q,
    output logic [BYTE_W-1:0]               msg_data,
    output logic                            msg_valid,
    input  logic                            msg_ready,
    output logic                            msg_last,
    output logic                            found,
    output logic                            all_failed,
    output logic [IDX_W-1:0]                winner_core,
    output logic [KEY_WIDTH-1:0]            final_key,
    output logic                            busy
);

    localparam int unsigned CNT_W = ADDR_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MESSAGE_LENGTH - 1);

    typedef enum logic [2:0] {
        ST_MONITOR,
        ST_DRAIN_ADDR,
        ST_DRAIN_WAIT,
        ST_DRAIN_CAP,
        ST_PRESENT,
        ST_COMPLETE,
        ST_FAILED
    } state_t;

    state_t                 state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic [CORE_NUMBER-1:0] fail_seen, fail_seen_d;
    logic [CORE_NUMBER-1:0] fail_now;

    logic                   done_d, found_d, all_failed_d, busy_d;
    logic                   msg_valid_d, msg_last_d;
    logic [ADDR_W-1:0]      rd_address_d;
    logic [BYTE_W-1:0]      msg_data_d;
    logic [IDX_W-1:0]       winner_core_d;
    logic [KEY_WIDTH-1:0]   final_key_d;

    logic [IDX_W-1:0]       crack_idx;
    logic [BYTE_W-1:0]      q_lane   [CORE_NUMBER];
    logic [KEY_WIDTH-1:0]   key_lane [CORE_NUMBER];

    // Unpack the per-core buses into indexable lanes.
    for (genvar g = 0; g < CORE_NUMBER; g++) begin : g_lane
        assign q_lane[g]   = rd_q[g*BYTE_W +: BYTE_W];
        assign key_lane[g] = core_key[g*KEY_WIDTH +: KEY_WIDTH];
    end

    // Lowest-index cracked core wins when several succeed together.
    always_comb begin
        crack_idx = '0;
        for (int i = int'(CORE_NUMBER) - 1; i >= 0; i--) begin
            if (core_cracked[i]) begin
                crack_idx = IDX_W'(i);
            end
        end
    end

    assign fail_now = fail_seen | core_failed;

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        fail_seen_d   = fail_seen;
        done_d        = done;
        found_d       = found;
        all_failed_d  = all_failed;
        busy_d        = busy;
        msg_valid_d   = msg_valid;
        msg_last_d    = msg_last;
        msg_data_d    = msg_data;
        rd_address_d  = rd_address;
        winner_core_d = winner_core;
        final_key_d   = final_key;

        case (state)
            ST_MONITOR: begin
                fail_seen_d = fail_now;
                if (|core_cracked) begin
                    winner_core_d = crack_idx;
                    final_key_d   = key_lane[crack_idx];
                    found_d       = 1'b1;
                    done_d        = 1'b1;
                    cnt_d         = '0;
                    state_d       = ST_DRAIN_ADDR;
                end else if (&fail_now) begin
                    all_failed_d = 1'b1;
                    done_d       = 1'b1;
                    state_d      = ST_FAILED;
                end
            end

            ST_DRAIN_ADDR: begin
                rd_address_d = cnt;
                busy_d       = 1'b1;
                state_d      = ST_DRAIN_WAIT;
            end

            // Covers the RAM read latency before capture.
            ST_DRAIN_WAIT: begin
                state_d = ST_DRAIN_CAP;
            end

            ST_DRAIN_CAP: begin
                msg_data_d  = q_lane[winner_core];
                msg_valid_d = 1'b1;
                msg_last_d  = (cnt == LAST_IDX);
                state_d     = ST_PRESENT;
            end

            ST_PRESENT: begin
                if (msg_valid && msg_ready) begin
                    msg_valid_d = 1'b0;
                    if (cnt == LAST_IDX) begin
                        msg_last_d = 1'b0;
                        busy_d     = 1'b0;
                        state_d    = ST_COMPLETE;
                    end else begin
                        cnt_d   = cnt + CNT_W'(1);
                        state_d = ST_DRAIN_ADDR;
                    end
                end
            end

            ST_COMPLETE: begin
                state_d = ST_COMPLETE;
            end

            ST_FAILED: begin
                state_d = ST_FAILED;
            end

            default: begin
                state_d = ST_MONITOR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_MONITOR;
            cnt         <= '0;
            fail_seen   <= '0;
            done        <= 1'b0;
            found       <= 1'b0;
            all_failed  <= 1'b0;
            busy        <= 1'b0;
            msg_valid   <= 1'b0;
            msg_last    <= 1'b0;
            msg_data    <= '0;
            rd_address  <= '0;
            winner_core <= '0;
            final_key   <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            fail_seen   <= fail_seen_d;
            done        <= done_d;
            found       <= found_d;
            all_failed  <= all_failed_d;
            busy        <= busy_d;
            msg_valid   <= msg_valid_d;
            msg_last    <= msg_last_d;
            msg_data    <= msg_data_d;
            rd_address  <= rd_address_d;
            winner_core <= winner_core_d;
            final_key   <= final_key_d;
        end
    end

endmodule

// File: tb/tb_crack_result_collector.sv
// Directed bench for crack_result_collector: crack/fail detection, priority, message streaming,
// backpressure and reset during a drain.
module tb_crack_result_collector;

    localparam int CN = 4;
    localparam int ML = 32;
    localparam int KW = 24;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CN-1:0]     core_cracked;
    logic [CN-1:0]     core_failed;
    logic [CN*KW-1:0]  core_key;
    logic              done;
    logic [4:0]        rd_address;
    logic [CN*8-1:0]   rd_q;
    logic [7:0]        msg_data;
    logic              msg_valid;
    logic              msg_ready;
    logic              msg_last;
    logic              found;
    logic              all_failed;
    logic [IW-1:0]     winner_core;
    logic [KW-1:0]     final_key;
    logic              busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [CN][ML];

    always #5 clk = ~clk;

    crack_result_collector #(
        .CORE_NUMBER(CN), .MESSAGE_LENGTH(ML), .KEY_WIDTH(KW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .core_cracked(core_cracked), .core_failed(core_failed), .core_key(core_key),
        .done(done), .rd_address(rd_address), .rd_q(rd_q),
        .msg_data(msg_data), .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_last(msg_last),
        .found(found), .all_failed(all_failed), .winner_core(winner_core),
        .final_key(final_key), .busy(busy)
    );

    // Per-core decrypted-message RAMs.
    for (genvar g = 0; g < CN; g++) begin : g_ram
        assign rd_q[g*8 +: 8] = ram[g][rd_address];
    end

    task automatic init_ram();
        string s;
        s = "the quick brown fox jumps over t";
        for (int i = 0; i < ML; i++) begin
            ram[0][i] = 8'(8'h57 + i);
            ram[1][i] = 8'(8'h80 + i);
            ram[2][i] = 8'(s[i]);
            ram[3][i] = 8'(8'hC0 + i);
        end
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        core_cracked = '0;
        core_failed  = '0;
        core_key     = '0;
        msg_ready    = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        core_cracked = '0;
        core_failed  = '0;
        core_key     = '0;
        msg_ready    = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({done, msg_valid, msg_last, found, all_failed, busy} !== 6'b0)
            $display("FAIL reset_flags got %b want 000000", {done, msg_valid, msg_last, found, all_failed, busy});
        if ({done, msg_valid, msg_last, found, all_failed, busy} !== 6'b0) errors++;
        checks++;
        if ({rd_address, msg_data, winner_core, final_key} !== '0) begin
            errors++;
            $display("FAIL reset_values got %h want 0", {rd_address, msg_data, winner_core, final_key});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({done, found, all_failed, busy, msg_valid} !== 5'b0) begin
            errors++;
            $display("FAIL idle_monitor got %b want 00000", {done, found, all_failed, busy, msg_valid});
        end
    endtask

    task automatic test_single_crack();
        int k = 0;
        int prev = 0;
        do_reset();
        core_key[2*KW +: KW] = 24'h1A2B3C;
        core_cracked = 4'b0100;
        @(negedge clk);
        checks++;
        if ({found, done} !== 2'b11) begin
            errors++;
            $display("FAIL crack_flags got %b want 11", {found, done});
        end
        checks++;
        if (winner_core !== 2'd2 || final_key !== 24'h1A2B3C) begin
            errors++;
            $display("FAIL crack_latch got %0d/%h want 2/1a2b3c", winner_core, final_key);
        end
        for (int cyc = 0; cyc < 200 && k < ML; cyc++) begin
            @(negedge clk);
            if (cyc == 20) core_cracked = 4'b0001;
            if (msg_valid) begin
                checks++;
                if (msg_data !== ram[2][k]) begin
                    errors++;
                    $display("FAIL single_data[%0d] got %h want %h", k, msg_data, ram[2][k]);
                end
                checks++;
                if (msg_last !== 1'(k == ML - 1)) begin
                    errors++;
                    $display("FAIL single_last[%0d] got %b want %b", k, msg_last, k == ML - 1);
                end
                if (k > 0) begin
                    checks++;
                    if (cyc - prev != 4) begin
                        errors++;
                        $display("FAIL single_spacing[%0d] got %0d want 4", k, cyc - prev);
                    end
                end
                prev = cyc;
                k++;
            end
        end
        checks++;
        if (k != ML) begin
            errors++;
            $display("FAIL single_count got %0d want %0d", k, ML);
        end
        @(negedge clk);
        checks++;
        if ({busy, msg_valid, msg_last, done, found} !== 5'b00011 || winner_core !== 2'd2) begin
            errors++;
            $display("FAIL single_complete got %b/%0d want 00011/2", {busy, msg_valid, msg_last, done, found}, winner_core);
        end
    endtask

    task automatic test_simultaneous_crack();
        int k = 0;
        do_reset();
        core_key[1*KW +: KW] = 24'h100000;
        core_key[3*KW +: KW] = 24'h300005;
        core_cracked = 4'b1010;
        @(negedge clk);
        checks++;
        if (winner_core !== 2'd1 || final_key !== 24'h100000 || found !== 1'b1) begin
            errors++;
            $display("FAIL priority got %0d/%h/%b want 1/100000/1", winner_core, final_key, found);
        end
        for (int cyc = 0; cyc < 200 && k < ML; cyc++) begin
            @(negedge clk);
            if (msg_valid) begin
                checks++;
                if (msg_data !== ram[1][k]) begin
                    errors++;
                    $display("FAIL priority_data[%0d] got %h want %h", k, msg_data, ram[1][k]);
                end
                k++;
            end
        end
        checks++;
        if (k != ML) begin
            errors++;
            $display("FAIL priority_count got %0d want %0d", k, ML);
        end
    endtask

    task automatic test_all_failed();
        do_reset();
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            checks++;
            if ({all_failed, done} !== 2'b00) begin
                errors++;
                $display("FAIL early_fail cyc %0d got %b want 00", cyc, {all_failed, done});
            end
            if (cyc == 10) core_failed[0] = 1'b1;
            if (cyc == 11) core_failed[0] = 1'b0;
            if (cyc == 20) core_failed[1] = 1'b1;
            if (cyc == 30) core_failed[2] = 1'b1;
            if (cyc == 40) core_failed[3] = 1'b1;
        end
        @(negedge clk);
        checks++;
        if ({all_failed, done, found} !== 3'b110) begin
            errors++;
            $display("FAIL all_failed got %b want 110", {all_failed, done, found});
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            checks++;
            if ({msg_valid, busy, done, all_failed} !== 4'b0011) begin
                errors++;
                $display("FAIL fail_hold cyc %0d got %b want 0011", cyc, {msg_valid, busy, done, all_failed});
            end
        end
    endtask

    task automatic test_fail_then_crack();
        int k = 0;
        do_reset();
        core_failed = 4'b0011;
        repeat (3) @(negedge clk);
        checks++;
        if ({all_failed, done} !== 2'b00) begin
            errors++;
            $display("FAIL partial_fail got %b want 00", {all_failed, done});
        end
        core_key[3*KW +: KW] = 24'h2FFFFE;
        core_cracked = 4'b1000;
        @(negedge clk);
        checks++;
        if ({found, done, all_failed} !== 3'b110 || winner_core !== 2'd3 || final_key !== 24'h2FFFFE) begin
            errors++;
            $display("FAIL fail_then_crack got %b/%0d/%h want 110/3/2ffffe", {found, done, all_failed}, winner_core, final_key);
        end
        for (int cyc = 0; cyc < 20 && k == 0; cyc++) begin
            @(negedge clk);
            if (msg_valid) begin
                checks++;
                if (msg_data !== ram[3][0] || all_failed !== 1'b0) begin
                    errors++;
                    $display("FAIL fail_then_crack_data got %h/%b want %h/0", msg_data, all_failed, ram[3][0]);
                end
                k++;
            end
        end
        checks++;
        if (k != 1) begin
            errors++;
            $display("FAIL fail_then_crack_timeout got %0d want 1", k);
        end
    endtask

    task automatic test_backpressure();
        int k = 0;
        int stall = 0;
        do_reset();
        core_key[0 +: KW] = 24'h000042;
        core_cracked = 4'b0001;
        for (int cyc = 0; cyc < 300 && k < ML; cyc++) begin
            @(negedge clk);
            if (k == 10 && stall > 0) begin
                checks++;
                if (msg_valid !== 1'b1 || msg_data !== 8'h61) begin
                    errors++;
                    $display("FAIL stall_hold %0d got %b/%h want 1/61", stall, msg_valid, msg_data);
                end
            end
            if (msg_valid) begin
                checks++;
                if (msg_data !== ram[0][k]) begin
                    errors++;
                    $display("FAIL bp_data[%0d] got %h want %h", k, msg_data, ram[0][k]);
                end
                if (k == 10 && stall < 5) begin
                    msg_ready = 1'b0;
                    stall++;
                end else begin
                    msg_ready = 1'b1;
                    k++;
                end
            end
        end
        checks++;
        if (k != ML || stall != 5) begin
            errors++;
            $display("FAIL bp_count got %0d/%0d want %0d/5", k, stall, ML);
        end
        msg_ready = 1'b1;
    endtask

    task automatic test_reset_mid_drain();
        int k = 0;
        int got = 0;
        do_reset();
        core_key[1*KW +: KW] = 24'h0ABCDE;
        core_cracked = 4'b0010;
        for (int cyc = 0; cyc < 200 && k < 8; cyc++) begin
            @(negedge clk);
            if (msg_valid) begin
                if (k == 7) begin
                    rst_n = 1'b0;
                    k = 8;
                end else begin
                    k++;
                end
            end
        end
        #1;
        checks++;
        if (k != 8 || {done, msg_valid, msg_last, found, all_failed, busy} !== 6'b0) begin
            errors++;
            $display("FAIL mid_reset_flags got %b (k=%0d) want 000000", {done, msg_valid, msg_last, found, all_failed, busy}, k);
        end
        checks++;
        if ({rd_address, msg_data, winner_core, final_key} !== '0) begin
            errors++;
            $display("FAIL mid_reset_values got %h want 0", {rd_address, msg_data, winner_core, final_key});
        end
        core_cracked = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({done, found, msg_valid, busy} !== 4'b0) begin
            errors++;
            $display("FAIL post_reset_monitor got %b want 0000", {done, found, msg_valid, busy});
        end
        core_key[0 +: KW] = 24'h000777;
        core_cracked = 4'b0001;
        @(negedge clk);
        checks++;
        if (found !== 1'b1 || winner_core !== 2'd0 || final_key !== 24'h000777) begin
            errors++;
            $display("FAIL restart_latch got %b/%0d/%h want 1/0/000777", found, winner_core, final_key);
        end
        for (int cyc = 0; cyc < 40 && got < 2; cyc++) begin
            @(negedge clk);
            if (msg_valid) begin
                checks++;
                if (msg_data !== ram[0][got] || rd_address !== 5'(got)) begin
                    errors++;
                    $display("FAIL restart_data[%0d] got %h@%0d want %h@%0d", got, msg_data, rd_address, ram[0][got], got);
                end
                got++;
            end
        end
        checks++;
        if (got != 2) begin
            errors++;
            $display("FAIL restart_timeout got %0d want 2", got);
        end
    endtask

    initial begin
        init_ram();
        test_reset();
        test_single_crack();
        test_simultaneous_crack();
        test_all_failed();
        test_fail_then_crack();
        test_backpressure();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/crack_result_collector.md
Name: crack_result_collector

Overview:
Sits directly downstream of the CORE_NUMBER parallel RC4 key-search cores. It monitors each core's cracked and failed flags and latches the first winning core and its 24-bit secret key. It broadcasts done to freeze every core, then reads the winner's 32-byte decrypted-message RAM and streams the plaintext out over a valid/ready interface. If every core fails, it raises all_failed instead.

Parameters:
CORE_NUMBER, 4, number of search cores monitored (1..8)
MESSAGE_LENGTH, 32, bytes in each decrypted-message RAM
KEY_WIDTH, 24, secret key width
IDX_W, $clog2(CORE_NUMBER) (min 1), winner index width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
core_cracked  in  CORE_NUMBER  per-core success flag (level, held by core)
core_failed  in  CORE_NUMBER  per-core exhaustion flag (level, held by core)
core_key  in  CORE_NUMBER*KEY_WIDTH  per-core final key; lane n = bits [n*KEY_WIDTH +: KEY_WIDTH]
done  out  1  broadcast to all cores; high = stop searching
rd_address  out  5  shared read address to every core's decrypted RAM
rd_q  in  CORE_NUMBER*8  per-core RAM read data; lane n = bits [n*8 +: 8]
msg_data  out  8  plaintext byte
msg_valid  out  1  msg_data is valid
msg_ready  in  1  consumer accepts the byte
msg_last  out  1  marks the final byte (index MESSAGE_LENGTH-1)
found  out  1  a key has been latched
all_failed  out  1  every core has exhausted its range
winner_core  out  IDX_W  index of the winning core
final_key  out  KEY_WIDTH  latched winning key
busy  out  1  high while draining the message

Behaviour:
- Reset (async, rst_n=0): state=MONITOR. done, msg_valid, msg_last, found, all_failed and busy are 0. rd_address, msg_data, winner_core and final_key are 0. The fail-sticky vector is cleared. Asserting reset mid-drain aborts the drain immediately with no further handshakes.
- State MONITOR:
  - Each cycle, OR core_failed into the sticky vector fail_seen.
  - If any core_cracked bit is set, the lowest set index wins. Latch winner_core and that lane's core_key into final_key. Set found=1 and done=1 on the next edge, then go to DRAIN_ADDR with byte counter cnt=0.
  - Otherwise, if fail_seen (including this cycle's core_failed) is all ones, set all_failed=1 and done=1, then go to FAIL.
  - A crack takes precedence over a failure in the same cycle.
- State DRAIN_ADDR: rd_address<=cnt, busy=1, then go to DRAIN_WAIT.
- State DRAIN_WAIT: a one-cycle wait, then go to DRAIN_CAP. RAM latency is 2 cycles from address to valid rd_q.
- State DRAIN_CAP: msg_data<=rd_q lane winner_core, msg_valid<=1, msg_last<=(cnt==MESSAGE_LENGTH-1), then go to PRESENT.
- State PRESENT: hold msg_data, msg_valid and msg_last stable while msg_ready=0. On a cycle with msg_valid&&msg_ready:
  - If this is the last byte: msg_valid<=0, msg_last<=0, busy<=0, go to COMPLETE.
  - Otherwise: msg_valid<=0, cnt<=cnt+1, go to DRAIN_ADDR.
- Throughput is at most one byte per 4 cycles. No byte may be skipped or duplicated.
- State COMPLETE: terminal. done, found, final_key and winner_core are held until reset.
- State FAIL: terminal. done=1, all_failed=1, found=0, msg_valid never asserts.
- cnt is 5 bits and never wraps past MESSAGE_LENGTH-1. core_cracked changes after latch are ignored, so the first winner is final.
- done is registered and never deasserts outside reset.

Test Plan:
- Core 2 raises cracked with key 0x1A2B3C; its RAM holds "the quick..." bytes, msg_ready=1 → next edge: found=1, done=1, winner_core=2, final_key=0x1A2B3C. 32 bytes stream in order, one every 4 cycles, msg_last only on byte 31, then COMPLETE with busy=0.
- Cores 1 and 3 raise cracked in the same cycle (keys 0x100000 and 0x300005) → winner_core=1, final_key=0x100000, and the stream comes from lane 1.
- Cores 0..3 raise failed at cycles 10, 20, 30 and 40 → all_failed=1 and done=1 one edge after cycle 40; found=0; msg_valid stays 0 forever.
- Cores 0 and 1 fail, then core 3 cracks with 0x2FFFFE → found path taken, all_failed stays 0.
- Hold msg_ready=0 for 5 cycles at byte 10 (value 0x61) → msg_data stays 0x61 and msg_valid stays 1 throughout; byte 11 follows only after the handshake; 32 bytes are delivered in total.
- Assert rst_n=0 while byte 7 is presented → all outputs go to 0 at once. After release, the block is in MONITOR, and a fresh crack by core 0 restarts the stream from byte 0.
